// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width, opcode encodings and the
// result-buffer occupancy state type.
package alu_pkg;

  localparam int unsigned ALU_N = 32;
  localparam int unsigned OP_W  = 4;

  localparam logic [OP_W-1:0] OP_AND  = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLT  = 4'b0111;
  localparam logic [OP_W-1:0] OP_NOR  = 4'b1100;
  localparam logic [OP_W-1:0] OP_PACK = 4'b1101;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry in-order buffer with valid/ready on both sides. The ready and
// valid handshakes come straight from the registered occupancy state.
module alu_skid_buf
  import alu_pkg::*;
#(
  parameter int unsigned W = ALU_N + OP_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid_i,
  output logic         push_ready_o,
  input  logic [W-1:0] push_data_i,
  output logic         pop_valid_o,
  input  logic         pop_ready_i,
  output logic [W-1:0] pop_data_o
);

  occ_e         state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         push, pop;

  assign push = push_valid_i && push_ready_o;
  assign pop  = pop_valid_o && pop_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OCC_EMPTY: if (push) state_d = OCC_ONE;
      OCC_ONE: begin
        if (push && !pop)      state_d = OCC_FULL;
        else if (pop && !push) state_d = OCC_EMPTY;
      end
      OCC_FULL:  if (pop) state_d = OCC_ONE;
      default:   state_d = OCC_EMPTY;
    endcase
  end

  always_comb begin
    push_ready_o = (state_q != OCC_FULL);
    pop_valid_o  = (state_q != OCC_EMPTY);
  end

  // Head always holds the oldest entry; tail is only live in FULL.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    case (state_q)
      OCC_EMPTY: if (push) head_d = push_data_i;
      OCC_ONE: begin
        if (push && pop) head_d = push_data_i;
        else if (push)   tail_d = push_data_i;
      end
      OCC_FULL:  if (pop) head_d = tail_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign pop_data_o = head_q;

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: buffers tagged results, derives zero/negative flags from
// the stored word and tracks ALU zero-flag disagreement. Statistics counters
// are built only when ALU_RESULT_STATS_EN is defined.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned N     = ALU_N,
  parameter int unsigned CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_out,
  input  logic            in_zero,
  input  logic [OP_W-1:0] in_op,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [N-1:0]    res_data,
  output logic [OP_W-1:0] res_op,
  output logic            res_zero,
  output logic            res_neg,
  output logic            flag_err
`ifdef ALU_RESULT_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_count,
  output logic [CNT_W-1:0] stat_zero
`endif
);

  localparam int unsigned PW = N + OP_W;

  if (N == 0 || CNT_W == 0) begin : g_param_check
    $error("alu_result_stage: N and CNT_W must be non-zero");
  end

  logic [PW-1:0] head;
  logic          push, pop;
  logic          flag_err_q, flag_err_d;

  alu_skid_buf #(
    .W(PW)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_valid_i(in_valid),
    .push_ready_o(in_ready),
    .push_data_i ({in_op, in_out}),
    .pop_valid_o (res_valid),
    .pop_ready_i (res_ready),
    .pop_data_o  (head)
  );

  assign push     = in_valid && in_ready;
  assign pop      = res_valid && res_ready;
  assign res_data = head[N-1:0];
  assign res_op   = head[PW-1:N];
  assign res_zero = (res_data == '0);
  assign res_neg  = res_data[N-1];

  // Sticky disagreement between the ALU zero flag and the accepted word.
  always_comb begin
    flag_err_d = flag_err_q;
    if (push && (in_zero != (in_out == '0))) flag_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_err_q <= 1'b0;
    end else begin
      flag_err_q <= flag_err_d;
    end
  end

  assign flag_err = flag_err_q;

`ifdef ALU_RESULT_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] zcnt_q, zcnt_d;

  // Saturating counts of popped results and popped zero results.
  always_comb begin
    cnt_d  = cnt_q;
    zcnt_d = zcnt_q;
    if (pop && (cnt_q != '1))             cnt_d  = cnt_q + CNT_W'(1);
    if (pop && res_zero && (zcnt_q != '1)) zcnt_d = zcnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      zcnt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      zcnt_q <= zcnt_d;
    end
  end

  assign stat_count = cnt_q;
  assign stat_zero  = zcnt_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios followed by
// randomized traffic against a queue-based reference model.
module tb_alu_result_stage;
  import alu_pkg::*;

  localparam int unsigned N   = 32;
  localparam int unsigned CW  = 2;
  localparam int unsigned SAT = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_out;
  logic            in_zero;
  logic [OP_W-1:0] in_op;
  logic            res_valid;
  logic            res_ready;
  logic [N-1:0]    res_data;
  logic [OP_W-1:0] res_op;
  logic            res_zero;
  logic            res_neg;
  logic            flag_err;
`ifdef ALU_RESULT_STATS_EN
  logic [CW-1:0]   stat_count;
  logic [CW-1:0]   stat_zero;
`endif

  always #5 clk = ~clk;

  alu_result_stage #(
    .N    (N),
    .CNT_W(CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_out   (in_out),
    .in_zero  (in_zero),
    .in_op    (in_op),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_op   (res_op),
    .res_zero (res_zero),
    .res_neg  (res_neg),
    .flag_err (flag_err)
`ifdef ALU_RESULT_STATS_EN
    ,
    .stat_count(stat_count),
    .stat_zero (stat_zero)
`endif
  );

  typedef struct {
    logic [N-1:0]    d;
    logic [OP_W-1:0] op;
  } ent_t;

  ent_t        mq[$];
  bit          m_flag;
  int unsigned m_cnt;
  int unsigned m_zcnt;
  bit          last_rst;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    ent_t h;
    chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    chk("res_valid", 64'(res_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      h = mq[0];
      chk("res_data", 64'(res_data), 64'(h.d));
      chk("res_op", 64'(res_op), 64'(h.op));
      chk("res_zero", 64'(res_zero), 64'(h.d == 0));
      chk("res_neg", 64'(res_neg), 64'(h.d[N-1]));
    end
    if (last_rst) begin
      chk("rst_data", 64'(res_data), 64'd0);
      chk("rst_op", 64'(res_op), 64'd0);
    end
    chk("flag_err", 64'(flag_err), 64'(m_flag));
`ifdef ALU_RESULT_STATS_EN
    chk("stat_count", 64'(stat_count), 64'(m_cnt));
    chk("stat_zero", 64'(stat_zero), 64'(m_zcnt));
`endif
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic step(input logic r, input logic v, input logic [N-1:0] d,
                      input logic z, input logic [OP_W-1:0] op, input logic rr);
    bit   do_push, do_pop;
    ent_t e;
    rst       = r;
    in_valid  = v;
    in_out    = d;
    in_zero   = z;
    in_op     = op;
    res_ready = rr;
    do_push   = v && (mq.size() < 2);
    do_pop    = rr && (mq.size() > 0);
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_flag = 1'b0;
      m_cnt  = 0;
      m_zcnt = 0;
    end else begin
      if (do_pop) begin
        e = mq.pop_front();
        if (m_cnt < SAT) m_cnt++;
        if (e.d == 0 && m_zcnt < SAT) m_zcnt++;
      end
      if (do_push) begin
        e.d  = d;
        e.op = op;
        mq.push_back(e);
        if (z != (d == 0)) m_flag = 1'b1;
      end
    end
    last_rst = r;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] d;
    logic         z;
    rst = 1'b1; in_valid = 1'b0; in_out = '0; in_zero = 1'b0; in_op = '0; res_ready = 1'b0;
    m_flag = 1'b0; m_cnt = 0; m_zcnt = 0; last_rst = 1'b0;

    // Reset state
    step(1, 0, 0, 0, 4'd0, 0);
    step(1, 1, 32'hDEAD_BEEF, 0, OP_OR, 1);

    // Single push, one-cycle latency, then ONE-state push+pop replacing head
    step(0, 1, 32'h5, 0, OP_ADD, 1);
    step(0, 1, 32'h7, 0, OP_SUB, 1);
    chk("req034_data", 64'(res_data), 64'h7);
    step(0, 0, 0, 0, 4'd0, 1);

    // Backpressure: third push rejected, drain yields 1 then 2
    step(0, 1, 32'h1, 0, OP_AND, 0);
    step(0, 1, 32'h2, 0, OP_SLT, 0);
    chk("req033_ready", 64'(in_ready), 64'd0);
    step(0, 1, 32'h3, 0, OP_NOR, 0);
    step(0, 0, 0, 0, 4'd0, 1);
    step(0, 0, 0, 0, 4'd0, 1);
    step(0, 0, 0, 0, 4'd0, 1);

    // Zero word with wrong ALU flag: sticky error, unknown opcode tag
    step(0, 1, 32'h0, 0, 4'hF, 1);
    chk("req035_zero", 64'(res_zero), 64'd1);
    step(0, 1, 32'h8000_0001, 0, OP_PACK, 1);
    step(0, 0, 0, 0, 4'd0, 1);

    // Rejected input while FULL must not raise flag_err
    step(1, 0, 0, 0, 4'd0, 0);
    step(0, 1, 32'hA, 0, OP_ADD, 0);
    step(0, 1, 32'hB, 0, OP_ADD, 0);
    step(0, 1, 32'h0, 0, OP_ADD, 0);
    chk("req024_flag", 64'(flag_err), 64'd0);

    // Reset while FULL with simultaneous push/pop requested
    step(1, 1, 32'hC, 1, OP_OR, 1);
    chk("req036_valid", 64'(res_valid), 64'd0);
    chk("req036_ready", 64'(in_ready), 64'd1);

`ifdef ALU_RESULT_STATS_EN
    // Five popped zero results saturate both 2-bit counters
    for (int i = 0; i < 5; i++) step(0, 1, 32'h0, 1, OP_SUB, 1);
    step(0, 0, 0, 0, 4'd0, 1);
    chk("req037_count", 64'(stat_count), 64'd3);
    chk("req037_zero", 64'(stat_zero), 64'd3);
    step(1, 0, 0, 0, 4'd0, 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 3))
        0:       d = '0;
        1:       d = N'($urandom_range(1, 15));
        2:       d = N'($urandom) | {1'b1, {(N-1){1'b0}}};
        default: d = N'($urandom);
      endcase
      z = (d == 0);
      if ($urandom_range(0, 15) == 0) z = ~z;
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 7), d, z,
           OP_W'($urandom_range(0, 15)), ($urandom_range(0, 9) < 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have parameter N, default 32, datapath width matching the ALU result.
REQ-002 SHALL have parameter CNT_W, default 16, width of statistics counters.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  ALU result present this cycle.
REQ-006 SHALL have port in_ready  output  1  stage can accept a result.
REQ-007 SHALL have port in_out  input  N  ALU result word.
REQ-008 SHALL have port in_zero  input  1  ALU-reported zero flag.
REQ-009 SHALL have port in_op  input  4  ALU opcode that produced the result.
REQ-010 SHALL have port res_valid  output  1  registered result available.
REQ-011 SHALL have port res_ready  input  1  consumer accepts result.
REQ-012 SHALL have port res_data  output  N  registered result.
REQ-013 SHALL have port res_op  output  4  opcode tagged with result.
REQ-014 SHALL have port res_zero  output  1  zero flag recomputed as res_data == 0.
REQ-015 SHALL have port res_neg  output  1  res_data[N-1].
REQ-016 SHALL have port flag_err  output  1  sticky: ALU zero flag disagreed with recomputed zero.

Function
REQ-017 SHALL buffer results in a 2-entry in-order buffer; transfer in when in_valid && in_ready, out when res_valid && res_ready.
REQ-018 SHALL track occupancy with states EMPTY, ONE, FULL: EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; ONE stays on simultaneous push+pop; FULL->ONE on pop.
REQ-019 SHALL drive in_ready = (state != FULL), purely from registered state (no combinational path from res_ready).
REQ-020 SHALL drive res_valid = (state != EMPTY); res_* SHALL show the oldest entry, stable while res_valid && !res_ready.
REQ-021 SHALL have latency one cycle: a push at edge k is visible on res_* after edge k when the buffer was EMPTY.
REQ-022 SHALL compute res_zero and res_neg from the stored word, not from in_zero.
REQ-023 SHALL set flag_err at the push edge when in_zero != (in_out == 0); cleared only by rst.
REQ-024 SHALL ignore in_valid while FULL (no overwrite, no flag_err update from rejected input).
REQ-025 SHALL treat opcode as opaque tag: unknown values stored and forwarded unchanged.

Reset
REQ-026 SHALL on rst force state EMPTY, in_ready 1 one cycle after, res_valid 0, res_data 0, res_op 0, flag_err 0, counters 0.
REQ-027 SHALL discard buffered entries when rst asserts mid-operation; rst takes priority over simultaneous push/pop.

Configuration
REQ-028 SHALL compile statistics only when macro ALU_RESULT_STATS_EN is defined: outputs stat_count (CNT_W, results popped) and stat_zero (CNT_W, popped results with res_zero=1), both saturating at all-ones.
REQ-029 SHALL, without ALU_RESULT_STATS_EN, omit stat_count/stat_zero ports and logic entirely.

Structure
REQ-030 SHALL take from shared package alu_pkg: default width constant N, 4-bit opcode constants (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, PACK 1101), occupancy state typedef.
REQ-031 SHALL place the 2-entry storage in one sub-module alu_skid_buf; flags and statistics stay in alu_result_stage.

Verification
REQ-032 SHALL cover: push in_out=32'h5, op=0010, res_ready=1 -> next cycle res_valid=1, res_data=5, res_zero=0, res_neg=0.
REQ-033 SHALL cover: res_ready=0, three pushes (1,2,3) -> in_ready=0 after second; third rejected; draining yields 1 then 2 only.
REQ-034 SHALL cover: ONE state, simultaneous push 7 and pop -> state ONE, res_data=7 next cycle.
REQ-035 SHALL cover: push in_out=0, in_zero=0 -> res_zero=1, flag_err=1 sticky until rst.
REQ-036 SHALL cover: FULL, assert rst one cycle -> res_valid=0, res_data=0, flag_err=0, in_ready=1.
REQ-037 SHALL cover (ALU_RESULT_STATS_EN, CNT_W=2): pop five zero results -> stat_count=3, stat_zero=3 (saturated).
